// File: rtl/beta_sequencer.sv
// Backward (beta) recursion sequencer for one max-product trellis block.
// Walks steps N-1..0, feeds beta_element, closes its feedback loop and stores betas N..0.
module beta_sequencer #(
    parameter int BITS           = 16,
    parameter int STATES         = 4,
    parameter int OUTPUT_SYMBOLS = 4,
    parameter int LEN_BITS       = 12,
    parameter logic [BITS-1:0] ONE_VALUE  = 16'h3C00,
    parameter logic [BITS-1:0] ZERO_VALUE = 16'h0000
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic [LEN_BITS-1:0]            block_len,
    input  logic                           terminated,
    output logic                           busy,
    output logic                           done,
    output logic                           bm_rd_en,
    output logic [LEN_BITS-1:0]            bm_rd_addr,
    input  logic [BITS*OUTPUT_SYMBOLS-1:0] bm_rd_data,
    output logic                           be_in_valid,
    output logic [BITS*OUTPUT_SYMBOLS-1:0] be_branch_metric,
    output logic [BITS*STATES-1:0]         be_next_beta,
    input  logic                           be_out_valid,
    input  logic [BITS*STATES-1:0]         be_beta,
    output logic                           beta_wr_en,
    output logic [LEN_BITS-1:0]            beta_wr_addr,
    output logic [BITS*STATES-1:0]         beta_wr_data
);

    localparam int BMW = BITS * OUTPUT_SYMBOLS;
    localparam int BW  = BITS * STATES;
    localparam logic [LEN_BITS-1:0] IDX_ONE = 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_READ,
        S_WAIT_RD,
        S_ISSUE,
        S_WAIT_BE,
        S_WRITE,
        S_DONE
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [LEN_BITS-1:0] k;
    logic [BW-1:0]       beta_reg;
    logic [BMW-1:0]      bm_reg;
    logic [BW-1:0]       next_beta_reg;

    // End-of-trellis vector: a terminated trellis can only finish in state 0.
    function automatic logic [BW-1:0] end_vector(input logic term);
        logic [BW-1:0] v;
        v = '0;
        for (int i = 0; i < STATES; i++) begin
            v[i*BITS +: BITS] = (i == 0 || !term) ? ONE_VALUE : ZERO_VALUE;
        end
        return v;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        busy        = 1'b0;
        done        = 1'b0;
        bm_rd_en    = 1'b0;
        be_in_valid = 1'b0;
        beta_wr_en  = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) state_next = S_INIT;
            end
            S_INIT: begin
                busy       = 1'b1;
                beta_wr_en = 1'b1;
                state_next = (k == '0) ? S_DONE : S_READ;
            end
            S_READ: begin
                busy       = 1'b1;
                bm_rd_en   = 1'b1;
                state_next = S_WAIT_RD;
            end
            S_WAIT_RD: begin
                busy       = 1'b1;
                state_next = S_ISSUE;
            end
            S_ISSUE: begin
                busy        = 1'b1;
                be_in_valid = 1'b1;
                state_next  = S_WAIT_BE;
            end
            S_WAIT_BE: begin
                busy = 1'b1;
                if (be_out_valid) state_next = S_WRITE;
            end
            S_WRITE: begin
                busy       = 1'b1;
                beta_wr_en = 1'b1;
                state_next = (k == '0) ? S_DONE : S_READ;
            end
            S_DONE: begin
                done       = 1'b1;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // The end vector is loaded when start is accepted so it is already on the
    // write port during INIT, which both writes beta_N and seeds the recursion.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            k             <= '0;
            beta_reg      <= '0;
            bm_reg        <= '0;
            next_beta_reg <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        k        <= block_len;
                        beta_reg <= end_vector(terminated);
                    end
                end
                S_INIT, S_WRITE: begin
                    if (k != '0) k <= k - IDX_ONE;
                end
                S_WAIT_RD: begin
                    bm_reg        <= bm_rd_data;
                    next_beta_reg <= beta_reg;
                end
                S_WAIT_BE: begin
                    if (be_out_valid) beta_reg <= be_beta;
                end
                default: ;
            endcase
        end
    end

    // beta_element operands come from their own registers so they stay frozen
    // after beta_reg takes the new result.
    assign bm_rd_addr       = k;
    assign beta_wr_addr     = k;
    assign beta_wr_data     = beta_reg;
    assign be_branch_metric = bm_reg;
    assign be_next_beta     = next_beta_reg;

endmodule
